// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit cache request to 16-bit async SRAM bridge
// Splits each word into low/high half-word phases of WAIT_CYCLES clocks each.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sram_address,
  input  logic [31:0] sram_wdata,
  input  logic        sram_read,
  input  logic        sram_write,
  output logic [31:0] sram_rdata,
  output logic        sram_ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS_LO, ACCESS_HI, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0] addr_off;
  logic        unused_addr_bits;
  logic        in_access;

  // Wrap-around below BASE_ADDR is intentional: the subtraction is mod 2^32.
  assign addr_off         = sram_address - BASE_ADDR;
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (sram_read || sram_write) begin
          state_d    = ACCESS_LO;
          cnt_d      = '0;
          word_d     = addr_off[18:2];
          wdata_d    = sram_wdata;
          is_write_d = sram_write;
        end
      end
      ACCESS_LO: begin
        if (cnt_q == LAST) begin
          state_d = ACCESS_HI;
          cnt_d   = '0;
          if (!is_write_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACCESS_HI: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!is_write_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
    end
  end

  // Pins decode only from registered state so request inputs never reach them.
  assign in_access  = (state_q == ACCESS_LO) || (state_q == ACCESS_HI);
  assign SRAM_ADDR  = in_access ? {word_q, (state_q == ACCESS_HI)} : 18'd0;
  assign SRAM_WE_N  = !(in_access && is_write_q);
  assign SRAM_OE_N  = !(in_access && !is_write_q);
  assign SRAM_DQ    = (in_access && is_write_q) ?
                      ((state_q == ACCESS_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
  assign SRAM_CE_N  = 1'b0;
  assign SRAM_UB_N  = 1'b0;
  assign SRAM_LB_N  = 1'b0;
  assign sram_ready = (state_q == DONE);
  assign sram_rdata = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed bench for sram_controller
// Includes a behavioural async SRAM that drives DQ only on OE_N=0, WE_N=1.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_read, sram_write;
  logic [31:0] sram_rdata;
  logic        sram_ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;
  logic        probe_en = 1'b0;

  sram_controller dut (
    .clk(clk), .rst(rst),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  always #5 clk = ~clk;

  assign SRAM_DQ = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] :
                   (probe_en ? 16'h0000 : 16'hzzzz);

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (!SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  // The bus reads back 0 only if nothing but the bench's probe drives it.
  task automatic check_bus_free(input string tag);
    probe_en = 1'b1;
    #1;
    check(tag, {16'h0, SRAM_DQ}, 32'h0);
    probe_en = 1'b0;
  endtask

  // Called in an IDLE cycle (cycle 0); returns in the ready cycle (cycle 5).
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [17:0] base,
                     input logic [31:0] exp_rdata);
    logic wr_eff;
    logic [15:0] half;
    wr_eff = wr;
    sram_read = rd; sram_write = wr; sram_address = addr; sram_wdata = wd;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) begin
        sram_address = 32'h0000_0F00;
        sram_wdata   = 32'h0BAD_0BAD;
      end
      check($sformatf("ready_c%0d", c), {31'h0, sram_ready}, {31'h0, (c == 5)});
      if (c <= 4) begin
        half = (c <= 2) ? wd[15:0] : wd[31:16];
        check($sformatf("addr_c%0d", c), {14'h0, SRAM_ADDR}, {14'h0, base + ((c > 2) ? 18'd1 : 18'd0)});
        check($sformatf("we_n_c%0d", c), {31'h0, SRAM_WE_N}, {31'h0, !wr_eff});
        check($sformatf("oe_n_c%0d", c), {31'h0, SRAM_OE_N}, {31'h0, wr_eff});
        if (wr_eff) check($sformatf("dq_wr_c%0d", c), {16'h0, SRAM_DQ}, {16'h0, half});
        else check($sformatf("dq_rd_c%0d", c), {16'h0, SRAM_DQ}, {16'h0, mem[base[9:0] + ((c > 2) ? 10'd1 : 10'd0)]});
      end
    end
    check("rdata_ready", sram_rdata, exp_rdata);
    sram_read = 1'b0; sram_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    sram_read = 1'b1; sram_write = 1'b0;
    sram_address = 32'd1024; sram_wdata = 32'h0;
    #2;
    repeat (3) tick();
    check("rst_ready", {31'h0, sram_ready}, 32'h0);
    check("rst_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    check("rst_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    check("rst_addr", {14'h0, SRAM_ADDR}, 32'h0);
    check("rst_rdata", sram_rdata, 32'h0);
    check_bus_free("rst_dq_z");
    sram_read = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("idle_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
      check("idle_ready", {31'h0, sram_ready}, 32'h0);
    end

    // Write 0xDEADBEEF at the base address
    txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 18'd0, 32'h0);
    tick();
    check("wr_ready_gone", {31'h0, sram_ready}, 32'h0);
    check("wr_mem0", {16'h0, mem[0]}, 32'h0000BEEF);
    check("wr_mem1", {16'h0, mem[1]}, 32'h0000DEAD);
    check_bus_free("post_wr_dq_z");

    // Read it back
    txn(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
    tick();
    check("rd_held", sram_rdata, 32'hDEADBEEF);

    // Cache refill: A then A^4 the cycle after ready
    preload(10'd4, 16'h2222);
    preload(10'd5, 16'h1111);
    preload(10'd6, 16'h4444);
    preload(10'd7, 16'h3333);
    txn(1'b1, 1'b0, 32'h408, 32'h0, 18'd4, 32'h11112222);
    tick();
    txn(1'b1, 1'b0, 32'h408 ^ 32'h4, 32'h0, 18'd6, 32'h33334444);
    tick();
    check("refill_held", sram_rdata, 32'h33334444);

    // Read and write together: write wins, rdata untouched
    txn(1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, 18'd2, 32'h33334444);
    tick();
    check("both_mem2", {16'h0, mem[2]}, 32'h0000F00D);
    check("both_mem3", {16'h0, mem[3]}, 32'h0000CAFE);
    check("both_rdata", sram_rdata, 32'h33334444);

    // Reset in cycle 3 of a write
    sram_write = 1'b1; sram_address = 32'd1036; sram_wdata = 32'h12345678;
    repeat (3) tick();
    check("mid_we_n_before", {31'h0, SRAM_WE_N}, 32'h0);
    rst = 1'b0;
    #1;
    check("abort_we_n", {31'h0, SRAM_WE_N}, 32'h1);
    check("abort_oe_n", {31'h0, SRAM_OE_N}, 32'h1);
    check("abort_addr", {14'h0, SRAM_ADDR}, 32'h0);
    check("abort_rdata", sram_rdata, 32'h0);
    check_bus_free("abort_dq_z");
    sram_write = 1'b0;
    repeat (3) begin
      tick();
      check("abort_no_ready", {31'h0, sram_ready}, 32'h0);
    end
    rst = 1'b1;
    tick();
    txn(1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 32'hDEADBEEF);
    tick();
    check("post_abort_idle", {31'h0, sram_ready}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
